// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU mux array, the result stage and the downstream consumer.
// The result stage uses the slave view; the producer/consumer side uses the master view.
interface alu_result_stage_if #(parameter int WIDTH = 64);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic [1:0]       in_sel;
    logic             in_carry;
    logic             in_ovf;
    logic             in_set_flags;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_n;
    logic             out_z;
    logic             out_c;
    logic             out_v;
    logic [3:0]       status;

    modport master (
        output in_valid, in_result, in_sel, in_carry, in_ovf, in_set_flags, out_ready,
        input  in_ready, out_valid, out_result, out_n, out_z, out_c, out_v, status
    );

    modport slave (
        input  in_valid, in_result, in_sel, in_carry, in_ovf, in_set_flags, out_ready,
        output in_ready, out_valid, out_result, out_n, out_z, out_c, out_v, status
    );
endinterface

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: computes N/Z/C/V, buffers up to two results in a skid FIFO,
// and commits flags to the status register when a flag-setting result is consumed.
module alu_result_stage #(
    parameter int WIDTH = 64
) (
    input logic              clk,
    input logic              reset,
    alu_result_stage_if.slave bus
);
    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             n;
        logic             z;
        logic             c;
        logic             v;
        logic             set_flags;
    } entry_t;

    entry_t     mem [2];
    entry_t     new_entry;
    entry_t     head;
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic [3:0] status_q;
    logic       push;
    logic       pop;

    // Carry and overflow only mean something for the add/sub select.
    always_comb begin
        new_entry           = '0;
        new_entry.result    = bus.in_result;
        new_entry.n         = bus.in_result[WIDTH-1];
        new_entry.z         = (bus.in_result == '0);
        new_entry.c         = (bus.in_sel == 2'b00) && bus.in_carry;
        new_entry.v         = (bus.in_sel == 2'b00) && bus.in_ovf;
        new_entry.set_flags = bus.in_set_flags;
    end

    // Handshake outputs come from the registered count only, keeping both sides free of comb paths.
    assign bus.in_ready  = (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    assign head           = mem[rd_ptr];
    assign bus.out_result = head.result;
    assign bus.out_n      = head.n;
    assign bus.out_z      = head.z;
    assign bus.out_c      = head.c;
    assign bus.out_v      = head.v;
    assign bus.status     = status_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            status_q <= 4'b0000;
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                if (head.set_flags) begin
                    status_q <= {head.n, head.z, head.c, head.v};
                end
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: flag rules, backpressure, push/pop overlap, async reset.
module tb_alu_result_stage;
    localparam int WIDTH = 64;

    logic clk;
    logic reset;
    int   checks;
    int   fails;

    alu_result_stage_if #(.WIDTH(WIDTH)) bus ();

    alu_result_stage #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic v, input logic [WIDTH-1:0] r, input logic [1:0] sel,
                          input logic c, input logic o, input logic sf);
        bus.in_valid     = v;
        bus.in_result    = r;
        bus.in_sel       = sel;
        bus.in_carry     = c;
        bus.in_ovf       = o;
        bus.in_set_flags = sf;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
        checks++;
        if (bus.out_result !== 64'd0) begin
            fails++; $display("FAIL reset_out_result: got %h expected 0", bus.out_result);
        end
        checks++;
        if ({bus.out_n, bus.out_z, bus.out_c, bus.out_v} !== 4'b0000) begin
            fails++; $display("FAIL reset_flags: got %b expected 0000",
                              {bus.out_n, bus.out_z, bus.out_c, bus.out_v});
        end
        checks++;
        if (bus.status !== 4'b0000) begin
            fails++; $display("FAIL reset_status: got %b expected 0000", bus.status);
        end
    endtask

    // Push one entry with out_ready high, check head one cycle later and status after the pop.
    task automatic push_and_commit(input string name, input logic [WIDTH-1:0] r, input logic [1:0] sel,
                                   input logic c, input logic o, input logic [3:0] exp_nzcv);
        bus.out_ready = 1'b1;
        set_in(1'b1, r, sel, c, o, 1'b1);
        @(negedge clk);
        set_in(1'b0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            fails++; $display("FAIL %s_valid: got %b expected 1", name, bus.out_valid);
        end
        checks++;
        if (bus.out_result !== r) begin
            fails++; $display("FAIL %s_result: got %h expected %h", name, bus.out_result, r);
        end
        checks++;
        if ({bus.out_n, bus.out_z, bus.out_c, bus.out_v} !== exp_nzcv) begin
            fails++; $display("FAIL %s_nzcv: got %b expected %b", name,
                              {bus.out_n, bus.out_z, bus.out_c, bus.out_v}, exp_nzcv);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            fails++; $display("FAIL %s_drained: got %b expected 0", name, bus.out_valid);
        end
        checks++;
        if (bus.status !== exp_nzcv) begin
            fails++; $display("FAIL %s_status: got %b expected %b", name, bus.status, exp_nzcv);
        end
    endtask

    task automatic test_flags();
        push_and_commit("add", 64'd90357, 2'b00, 1'b0, 1'b0, 4'b0000);
        push_and_commit("zero_carry", 64'd0, 2'b00, 1'b1, 1'b0, 4'b0110);
        push_and_commit("xor_mask", 64'h8000_0000_0000_0000, 2'b11, 1'b1, 1'b1, 4'b1000);
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        set_in(1'b1, 64'd256, 2'b01, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL bp_ready_one: got %b expected 1", bus.in_ready);
        end
        set_in(1'b1, 64'd128, 2'b10, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            fails++; $display("FAIL bp_ready_full: got %b expected 0", bus.in_ready);
        end
        set_in(1'b1, 64'd999, 2'b00, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        set_in(1'b0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.out_result !== 64'd256) begin
            fails++; $display("FAIL bp_hold: got %h expected %h", bus.out_result, 64'd256);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            fails++; $display("FAIL bp_still_full: got %b expected 0", bus.in_ready);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_result !== 64'd128) begin
            fails++; $display("FAIL bp_second: got %h expected %h", bus.out_result, 64'd128);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL bp_ready_back: got %b expected 1", bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            fails++; $display("FAIL bp_no_extra: got %b expected 0", bus.out_valid);
        end
        checks++;
        if (bus.status !== 4'b1000) begin
            fails++; $display("FAIL bp_status_hold: got %b expected 1000", bus.status);
        end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        set_in(1'b1, 64'd7, 2'b01, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.out_ready = 1'b1;
        set_in(1'b1, 64'd5, 2'b00, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        set_in(1'b0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL b2b_count_one: got valid %b ready %b expected 1 1",
                              bus.out_valid, bus.in_ready);
        end
        checks++;
        if (bus.out_result !== 64'd5) begin
            fails++; $display("FAIL b2b_head: got %h expected %h", bus.out_result, 64'd5);
        end
        checks++;
        if (bus.status !== 4'b1000) begin
            fails++; $display("FAIL b2b_noflag_pop: got %b expected 1000", bus.status);
        end
        @(negedge clk);
        checks++;
        if (bus.status !== 4'b0010) begin
            fails++; $display("FAIL b2b_commit: got %b expected 0010", bus.status);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            fails++; $display("FAIL b2b_empty: got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        set_in(1'b1, 64'hFFFF_0000_0000_0011, 2'b00, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        set_in(1'b1, 64'd22, 2'b00, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        set_in(1'b0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            fails++; $display("FAIL mid_full: got %b expected 0", bus.in_ready);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL mid_async: got valid %b ready %b expected 0 1",
                              bus.out_valid, bus.in_ready);
        end
        checks++;
        if (bus.status !== 4'b0000) begin
            fails++; $display("FAIL mid_status: got %b expected 0000", bus.status);
        end
        checks++;
        if (bus.out_result !== 64'd0) begin
            fails++; $display("FAIL mid_result: got %h expected 0", bus.out_result);
        end
        @(negedge clk);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                fails++; $display("FAIL mid_stale_%0d: got %b expected 0", i, bus.out_valid);
            end
        end
        checks++;
        if (bus.status !== 4'b0000) begin
            fails++; $display("FAIL mid_status_after: got %b expected 0000", bus.status);
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        reset  = 1'b1;
        bus.out_ready = 1'b0;
        set_in(1'b0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_flags();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage placed directly downstream of the ALU's per-bit 4:1 result multiplexer array. It captures the WIDTH-bit selected result with its adder carry/overflow and computes N/Z/C/V condition flags. It buffers up to two results in a skid FIFO behind a valid/ready handshake, and commits flags to a persistent status register as results are consumed.

## Interface
- WIDTH, 64, result width; one mux slice per bit upstream.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  upstream result present this cycle.
- in_ready  out  1  stage can accept; high when fewer than 2 entries held.
- in_result  in  WIDTH  mux-array output.
- in_sel  in  2  mux select that produced in_result: 00 add/sub, 01 AND, 10 OR, 11 XOR.
- in_carry  in  1  adder carry-out, meaningful only for sel 00.
- in_ovf  in  1  adder signed overflow, meaningful only for sel 00.
- in_set_flags  in  1  result updates status register when consumed.
- out_valid  out  1  head entry present.
- out_ready  in  1  downstream accepts head entry.
- out_result  out  WIDTH  head entry result.
- out_n, out_z, out_c, out_v  out  1 each  flags of head entry.
- status  out  4  committed flags {N,Z,C,V}.

## Operation
- Push: in_valid && in_ready at rising edge writes entry {result, N, Z, C, V, set_flags}.
- Pop: out_valid && out_ready at rising edge removes head entry.
- Flag rules per entry, computed at push:
  - N = in_result[WIDTH-1].
  - Z = 1 iff in_result == 0.
  - C = in_carry when in_sel == 00, else 0.
  - V = in_ovf when in_sel == 00, else 0.
- Storage: 2-entry FIFO; wr_ptr, rd_ptr 1 bit each, count 0..2; pointers wrap 1 -> 0.
- in_ready = (count != 2); out_valid = (count != 0); both derived from registered count only, with no combinational path from out_ready or in_valid.
- Simultaneous push and pop with count 1: count stays 1, head advances, new entry written to the freed slot.
- Simultaneous push and pop with count 0: not possible, since out_valid is low; the push alone occurs.
- Count 2: in_ready low, so no push; a pop still proceeds.
- Status register: on a pop whose entry has set_flags = 1, status <= {N,Z,C,V} of that entry. Otherwise status holds.
- Out-of-range conditions: none; in_sel is fully decoded.

## Timing
- Reset values: count 0, pointers 0, out_valid 0, in_ready 1, out_result 0, out_n/z/c/v 0, status 4'b0000.
- Reset mid-operation: asynchronous clear. Held entries are discarded and no status update occurs.
- First cycle after reset deasserts: in_ready = 1.
- Latency: entry pushed at edge k appears with out_valid = 1 after edge k, visible in cycle k+1.
- Throughput: one result per cycle sustained when out_ready is held high.
- Status: updates on the same edge as the committing pop; visible the following cycle.
- Output hold: out_result and flags stay stable while out_valid && !out_ready.

## Test plan
- Reset, then push in_result = 64'd64357 + 26000 = 64'd90357 with sel 00, carry 0, ovf 0, set_flags 1, out_ready 1 -> next cycle out_result = 90357, NZCV = 0000; status = 0000 one cycle after the pop.
- Push sel 00, in_result 0, carry 1, ovf 0, set_flags 1 -> head NZCV = 0110; after pop, status = 0110.
- Push sel 11, in_result 64'h8000_0000_0000_0000, carry 1, ovf 1, set_flags 1 -> NZCV = 1000, because C and V are masked for non-add; status = 1000 after pop.
- out_ready 0, push 256 then 128 -> in_ready drops after the second push and a third in_valid is not accepted. Raise out_ready -> 256 then 128 emerge in order; in_ready returns high after the first pop.
- Count 1 with simultaneous push 64'd5 and pop -> count stays 1 and the next head = 5. An entry with set_flags 0 popped -> status unchanged.
- Assert reset while 2 entries are held -> out_valid 0 and in_ready 1 immediately (asynchronous); status 0000; no stale entry emerges after release.
